// File: rtl/jc_slot_sched.sv
// Frame-based round-robin slot scheduler. A Johnson phase counter defines frames;
// grants change only on frame boundaries, with a per-grant frame budget.
module jc_slot_sched #(
  parameter int WIDTH      = 4,
  parameter int NREQ       = 4,
  parameter int MAX_FRAMES = 2
) (
  input  logic             i_clk,
  input  logic             i_arstn,
  input  logic             i_en,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ-1:0]  i_rel,
  output logic [NREQ-1:0]  o_gnt,
  output logic [WIDTH-1:0] o_phase,
  output logic             o_frame,
  output logic             o_busy
);
  localparam int CW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] LAST_PH = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_FR = CW'(MAX_FRAMES - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_phase;
  logic             r_frame;
  logic [NREQ-1:0]  r_gnt, w_nxt_gnt;
  logic [PW-1:0]    r_ptr, w_nxt_ptr, w_win;
  logic [CW-1:0]    r_fcnt, w_nxt_fcnt;
  logic             w_win_vld, w_hold_req, w_hold_rel;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_phase <= '0;
      r_frame <= 1'b0;
    end else begin
      if (i_en) r_phase <= {r_phase[WIDTH-2:0], ~r_phase[WIDTH-1]};
      r_frame <= i_en && (r_phase == LAST_PH);
    end
  end

  // Round-robin scan starting just after the last winner.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_win_vld && i_req[(int'(r_ptr) + i) % NREQ]) begin
        w_win_vld = 1'b1;
        w_win     = PW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  // Only the holder's own bits matter; masking with the grant ignores the rest.
  assign w_hold_req = |(i_req & r_gnt);
  assign w_hold_rel = |(i_rel & r_gnt);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_ptr   = r_ptr;
    w_nxt_fcnt  = r_fcnt;
    case (r_state)
      S_IDLE: begin
        w_nxt_gnt = '0;
        if (r_frame && w_win_vld) begin
          w_nxt_gnt   = NREQ'(1) << w_win;
          w_nxt_ptr   = w_win;
          w_nxt_fcnt  = '0;
          w_nxt_state = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_hold_rel || !w_hold_req) begin
          w_nxt_gnt   = '0;
          w_nxt_state = S_IDLE;
        end else if (r_frame && (r_fcnt == LAST_FR)) begin
          w_nxt_gnt   = '0;
          w_nxt_state = S_IDLE;
        end else if (r_frame) begin
          w_nxt_fcnt = r_fcnt + CW'(1);
        end
      end
      default: begin
        w_nxt_gnt   = '0;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_fcnt  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_ptr   <= w_nxt_ptr;
      r_fcnt  <= w_nxt_fcnt;
    end
  end

  assign o_gnt   = r_gnt;
  assign o_phase = r_phase;
  assign o_frame = r_frame;
  assign o_busy  = |r_gnt;
endmodule

// File: tb/tb_jc_slot_sched.sv
// Directed bench for jc_slot_sched: checkpoint table plus hand-written corner sequences.
module tb_jc_slot_sched;
  logic       i_clk = 1'b0;
  logic       i_arstn = 1'b0;
  logic       i_en = 1'b1;
  logic [3:0] i_req = '0;
  logic [3:0] i_rel = '0;
  logic [3:0] o_gnt;
  logic [3:0] o_phase;
  logic       o_frame;
  logic       o_busy;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  jc_slot_sched #(.WIDTH(4), .NREQ(4), .MAX_FRAMES(2)) dut (
    .i_clk(i_clk), .i_arstn(i_arstn), .i_en(i_en), .i_req(i_req), .i_rel(i_rel),
    .o_gnt(o_gnt), .o_phase(o_phase), .o_frame(o_frame), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         scen;
    int         edg;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] phase;
    logic       frame;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  // Next posedge after this task is edge 1.
  task automatic do_reset();
    i_arstn = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    i_arstn = 1'b1;
    cyc = 0;
  endtask

  task automatic add(input int s, input int e, input logic [3:0] rq, input logic [3:0] g,
                     input logic [3:0] ph, input logic fr);
    vec_t v;
    v.scen = s; v.edg = e; v.req = rq; v.gnt = g; v.phase = ph; v.frame = fr;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    // Scenario 0: no requests, phase and frame pulse timing.
    add(0, 0,  4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(0, 1,  4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(0, 4,  4'b0000, 4'b0000, 4'b1111, 1'b0);
    add(0, 7,  4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(0, 8,  4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(0, 9,  4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(0, 16, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    // Scenario 1: two requesters held, budget of two frames, round-robin.
    add(1, 0,  4'b0101, 4'b0000, 4'b0000, 1'b0);
    add(1, 8,  4'b0101, 4'b0000, 4'b0000, 1'b1);
    add(1, 9,  4'b0101, 4'b0001, 4'b0001, 1'b0);
    add(1, 24, 4'b0101, 4'b0001, 4'b0000, 1'b1);
    add(1, 25, 4'b0101, 4'b0000, 4'b0001, 1'b0);
    add(1, 32, 4'b0101, 4'b0000, 4'b0000, 1'b1);
    add(1, 33, 4'b0101, 4'b0100, 4'b0001, 1'b0);
    add(1, 48, 4'b0101, 4'b0100, 4'b0000, 1'b1);
    add(1, 49, 4'b0101, 4'b0000, 4'b0001, 1'b0);
    add(1, 57, 4'b0101, 4'b0001, 4'b0001, 1'b0);

    prev = -1;
    foreach (vt[k]) begin
      if (vt[k].scen != prev) begin
        i_req = vt[k].req; i_rel = '0; i_en = 1'b1;
        do_reset();
        prev = vt[k].scen;
      end
      i_req = vt[k].req;
      run_to(vt[k].edg);
      chk($sformatf("tbl%0d.gnt", k),   {4'b0, o_gnt},   {4'b0, vt[k].gnt});
      chk($sformatf("tbl%0d.phase", k), {4'b0, o_phase}, {4'b0, vt[k].phase});
      chk($sformatf("tbl%0d.frame", k), {7'b0, o_frame}, {7'b0, vt[k].frame});
      chk($sformatf("tbl%0d.busy", k),  {7'b0, o_busy},  {7'b0, |vt[k].gnt});
    end

    // Early release by holder; non-holder release ignored.
    i_req = 4'b0101; i_rel = '0; i_en = 1'b1;
    do_reset();
    run_to(10);
    i_rel = 4'b0100; step(); i_rel = '0;
    chk("rel_nonholder.gnt", {4'b0, o_gnt}, 8'h01);
    run_to(12);
    i_rel = 4'b0001; step(); i_rel = '0;
    chk("rel_early.gnt", {4'b0, o_gnt}, 8'h00);
    chk("rel_early.busy", {7'b0, o_busy}, 8'h00);
    run_to(16);
    chk("rel_early.gap", {4'b0, o_gnt}, 8'h00);
    step();
    chk("rel_early.next", {4'b0, o_gnt}, 8'h04);

    // Release on the o_frame cycle: no same-cycle re-arbitration.
    do_reset();
    run_to(16);
    chk("rel_frame.pre", {3'b0, o_frame, o_gnt}, 8'h11);
    i_rel = 4'b0001; step(); i_rel = '0;
    chk("rel_frame.drop", {4'b0, o_gnt}, 8'h00);
    run_to(24);
    chk("rel_frame.wait", {4'b0, o_gnt}, 8'h00);
    step();
    chk("rel_frame.next", {4'b0, o_gnt}, 8'h04);

    // Five enable-low cycles mid-grant delay expiry by five edges.
    do_reset();
    run_to(10);
    chk("freeze.start", {o_phase, o_gnt}, 8'h31);
    i_en = 1'b0;
    run_to(13);
    chk("freeze.mid", {3'b0, o_frame, o_phase}, 8'h03);
    run_to(15);
    chk("freeze.end", {o_phase, o_gnt}, 8'h31);
    i_en = 1'b1;
    run_to(25);
    chk("freeze.noexp", {4'b0, o_gnt}, 8'h01);
    run_to(29);
    chk("freeze.frame", {3'b0, o_frame, o_gnt}, 8'h11);
    step();
    chk("freeze.expire", {4'b0, o_gnt}, 8'h00);

    // o_frame does not repeat while phase is held at zero.
    do_reset();
    run_to(8);
    chk("hold0.frame", {3'b0, o_frame, o_phase}, 8'h10);
    i_en = 1'b0;
    step();
    chk("hold0.norepeat", {3'b0, o_frame, o_phase}, 8'h00);
    step();
    chk("hold0.norepeat2", {3'b0, o_frame, o_phase}, 8'h00);
    i_en = 1'b1;

    // Asynchronous reset mid-grant, then priority restarts at requester 0.
    i_req = 4'b1011;
    do_reset();
    i_req = 4'b0010;
    run_to(20);
    chk("arst.pre", {4'b0, o_gnt}, 8'h02);
    #2;
    i_arstn = 1'b0;
    #1;
    chk("arst.gnt", {4'b0, o_gnt}, 8'h00);
    chk("arst.phase_busy", {3'b0, o_busy, o_phase}, 8'h00);
    i_req = 4'b1001;
    do_reset();
    run_to(9);
    chk("arst.prio", {4'b0, o_gnt}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
